// File: rtl/ie_stage_if.sv
// Bundle between the id_ie register, the MIPS execute stage and its EX/MEM outputs.
// master = upstream/driver side, slave = ie_stage.
interface ie_stage_if;
    logic [31:0] read_data_1_in;
    logic [31:0] read_data_2_in;
    logic [31:0] sign_extended_imm_in;
    logic [4:0]  rt_in;
    logic [4:0]  rd_in;
    logic [31:0] next_pc_in;
    logic [3:0]  alu_op_in;
    logic        alu_src_in;
    logic        reg_dst_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        mem_to_reg_in;
    logic [31:0] alu_result_out;
    logic [31:0] write_data_out;
    logic [4:0]  write_reg_out;
    logic [31:0] branch_target_out;
    logic        zero_out;
    logic        reg_write_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        mem_to_reg_out;
    logic        stall_out;

    modport master (
        output read_data_1_in, read_data_2_in, sign_extended_imm_in, rt_in, rd_in,
               next_pc_in, alu_op_in, alu_src_in, reg_dst_in, reg_write_in,
               mem_read_in, mem_write_in, mem_to_reg_in,
        input  alu_result_out, write_data_out, write_reg_out, branch_target_out,
               zero_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out,
               stall_out
    );

    modport slave (
        input  read_data_1_in, read_data_2_in, sign_extended_imm_in, rt_in, rd_in,
               next_pc_in, alu_op_in, alu_src_in, reg_dst_in, reg_write_in,
               mem_read_in, mem_write_in, mem_to_reg_in,
        output alu_result_out, write_data_out, write_reg_out, branch_target_out,
               zero_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out,
               stall_out
    );
endinterface

// File: rtl/ie_stage.sv
// MIPS execute stage: ALU, branch target, EX/MEM register and optional iterative MULTU/DIVU.
// The mul/div engine, HI/LO and stall logic exist only when IE_MULDIV_EN is defined.
module ie_stage #(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    ie_stage_if.slave   bus
);
    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8,  OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_LUI  = 4'd11;
    localparam logic [3:0] OP_MULT = 4'd12, OP_DIVU = 4'd13, OP_MFHI = 4'd14, OP_MFLO = 4'd15;

    logic        [31:0] w_op_b;
    logic        [4:0]  w_shamt;
    logic signed [31:0] w_rs_s;
    logic signed [31:0] w_opb_s;
    logic signed [31:0] w_rt_s;
    logic               w_is_md;
    logic        [31:0] w_hi;
    logic        [31:0] w_lo;
    logic        [31:0] w_alu_result;
    logic               w_stall;

    assign w_op_b  = bus.alu_src_in ? bus.sign_extended_imm_in : bus.read_data_2_in;
    assign w_shamt = bus.sign_extended_imm_in[10:6];
    assign w_rs_s  = bus.read_data_1_in;
    assign w_opb_s = w_op_b;
    assign w_rt_s  = bus.read_data_2_in;
    assign w_is_md = (bus.alu_op_in == OP_MULT) || (bus.alu_op_in == OP_DIVU);

    always_comb begin
        w_alu_result = '0;
        case (bus.alu_op_in)
            OP_ADD:  w_alu_result = bus.read_data_1_in + w_op_b;
            OP_SUB:  w_alu_result = bus.read_data_1_in - w_op_b;
            OP_AND:  w_alu_result = bus.read_data_1_in & w_op_b;
            OP_OR:   w_alu_result = bus.read_data_1_in | w_op_b;
            OP_XOR:  w_alu_result = bus.read_data_1_in ^ w_op_b;
            OP_NOR:  w_alu_result = ~(bus.read_data_1_in | w_op_b);
            OP_SLT:  w_alu_result = {31'b0, w_rs_s < w_opb_s};
            OP_SLTU: w_alu_result = {31'b0, bus.read_data_1_in < w_op_b};
            OP_SLL:  w_alu_result = bus.read_data_2_in << w_shamt;
            OP_SRL:  w_alu_result = bus.read_data_2_in >> w_shamt;
            OP_SRA:  w_alu_result = w_rt_s >>> w_shamt;
            OP_LUI:  w_alu_result = {bus.sign_extended_imm_in[15:0], 16'h0000};
            OP_MFHI: w_alu_result = w_hi;
            OP_MFLO: w_alu_result = w_lo;
            default: ;
        endcase
    end

`ifdef IE_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // Fewer iterations than bits means several shift/subtract steps per cycle.
    localparam int         STEPS_PER_ITER = (32 + MULDIV_CYCLES - 1) / MULDIV_CYCLES;
    localparam logic [5:0] CNT_LAST       = 6'(MULDIV_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_stall_fsm;
    logic [5:0]  r_cnt;
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic [31:0] r_opnd;
    logic        r_is_div;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] w_acc;
    logic        w_last;

    // MULTU: {hi,lo} shifts right, hi accumulates. DIVU: hi is the partial remainder, lo collects quotient bits.
    function automatic logic [63:0] muldiv_step(input logic is_div, input logic [31:0] hi,
                                                input logic [31:0] lo, input logic [31:0] d);
        logic [32:0] sum;
        logic [32:0] rem;
        logic [32:0] diff;
        if (!is_div) begin
            sum = {1'b0, hi} + (lo[0] ? {1'b0, d} : 33'd0);
            return {sum, lo[31:1]};
        end
        rem  = {hi, lo[31]};
        diff = rem - {1'b0, d};
        if (rem >= {1'b0, d}) return {diff[31:0], lo[30:0], 1'b1};
        return {rem[31:0], lo[30:0], 1'b0};
    endfunction

    assign w_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_acc = {r_acc_hi, r_acc_lo};
        for (int k = 0; k < STEPS_PER_ITER; k++) begin
            if (int'(r_cnt) * STEPS_PER_ITER + k < 32)
                w_acc = muldiv_step(r_is_div, w_acc[63:32], w_acc[31:0], r_opnd);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall_fsm = 1'b0;
        case (r_state)
            S_IDLE: if (w_is_md) begin
                w_stall_fsm = 1'b1;
                w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                w_stall_fsm = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: if (w_is_md) begin
                    r_cnt    <= '0;
                    r_acc_hi <= '0;
                    r_acc_lo <= (bus.alu_op_in == OP_DIVU) ? bus.read_data_1_in : bus.read_data_2_in;
                    r_opnd   <= (bus.alu_op_in == OP_DIVU) ? bus.read_data_2_in : bus.read_data_1_in;
                    r_is_div <= (bus.alu_op_in == OP_DIVU);
                end
                S_BUSY: begin
                    r_acc_hi <= w_acc[63:32];
                    r_acc_lo <= w_acc[31:0];
                    r_cnt    <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_hi <= w_acc[63:32];
                        r_lo <= w_acc[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_stall = reset & w_stall_fsm;
    assign w_hi    = r_hi;
    assign w_lo    = r_lo;
`else
    logic [5:0] w_unused_cfg;
    assign w_unused_cfg = 6'(MULDIV_CYCLES);
    assign w_stall      = 1'b0;
    assign w_hi         = '0;
    assign w_lo         = '0;
`endif

    logic [31:0] r_alu_result_p1;
    logic [31:0] r_write_data_p1;
    logic [4:0]  r_write_reg_p1;
    logic [31:0] r_branch_target_p1;
    logic        r_zero_p1;
    logic        r_reg_write_p1;
    logic        r_mem_read_p1;
    logic        r_mem_write_p1;
    logic        r_mem_to_reg_p1;

    // EX/MEM boundary: a stall inserts a bubble, a mul/div retires without a register write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_alu_result_p1    <= '0;
            r_write_data_p1    <= '0;
            r_write_reg_p1     <= '0;
            r_branch_target_p1 <= '0;
            r_zero_p1          <= 1'b0;
            r_reg_write_p1     <= 1'b0;
            r_mem_read_p1      <= 1'b0;
            r_mem_write_p1     <= 1'b0;
            r_mem_to_reg_p1    <= 1'b0;
        end else if (w_stall) begin
            r_reg_write_p1     <= 1'b0;
            r_mem_read_p1      <= 1'b0;
            r_mem_write_p1     <= 1'b0;
            r_mem_to_reg_p1    <= 1'b0;
        end else begin
            r_alu_result_p1    <= w_alu_result;
            r_write_data_p1    <= bus.read_data_2_in;
            r_write_reg_p1     <= bus.reg_dst_in ? bus.rd_in : bus.rt_in;
            r_branch_target_p1 <= bus.next_pc_in + {bus.sign_extended_imm_in[29:0], 2'b00};
            r_zero_p1          <= (w_alu_result == 32'd0);
            r_reg_write_p1     <= bus.reg_write_in & ~w_is_md;
            r_mem_read_p1      <= bus.mem_read_in;
            r_mem_write_p1     <= bus.mem_write_in;
            r_mem_to_reg_p1    <= bus.mem_to_reg_in;
        end
    end

    assign bus.alu_result_out    = r_alu_result_p1;
    assign bus.write_data_out    = r_write_data_p1;
    assign bus.write_reg_out     = r_write_reg_p1;
    assign bus.branch_target_out = r_branch_target_p1;
    assign bus.zero_out          = r_zero_p1;
    assign bus.reg_write_out     = r_reg_write_p1;
    assign bus.mem_read_out      = r_mem_read_p1;
    assign bus.mem_write_out     = r_mem_write_p1;
    assign bus.mem_to_reg_out    = r_mem_to_reg_p1;
    assign bus.stall_out         = w_stall;
endmodule

// File: tb/tb_ie_stage.sv
// Randomized bench for ie_stage against a behavioural model, plus directed literal checks.
// Model follows IE_MULDIV_EN the same way the design does.
module tb_ie_stage;
    localparam int MULDIV_CYCLES = 32;
`ifdef IE_MULDIV_EN
    localparam int          EXP_STALL = MULDIV_CYCLES + 1;
    localparam logic [31:0] EXP_MUL_LO = 32'hFFFFFFFE, EXP_MUL_HI = 32'h1;
    localparam logic [31:0] EXP_DIV_LO = 32'hFFFFFFFF, EXP_DIV_HI = 32'h7;
`else
    localparam int          EXP_STALL = 0;
    localparam logic [31:0] EXP_MUL_LO = 32'h0, EXP_MUL_HI = 32'h0;
    localparam logic [31:0] EXP_DIV_LO = 32'h0, EXP_DIV_HI = 32'h0;
`endif

    logic clk = 1'b0;
    logic reset;
    ie_stage_if bus();

    ie_stage #(.MULDIV_CYCLES(MULDIV_CYCLES)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] e_alu, e_wdata, e_bt;
    logic [4:0]  e_wreg;
    logic        e_zero, e_rw, e_mr, e_mw, e_m2r;
    bit          e_alu_care = 1'b0;
    bit          m_valid = 1'b0;
    int          m_left = 0;
    bit          m_done = 1'b0;
    bit          m_div = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_md(input logic [3:0] op);
        return (op == 4'd12) || (op == 4'd13);
    endfunction

    // Stall is owed while a mul/div is counting down, or when one arrives with none pending retirement.
    function bit model_stall();
`ifdef IE_MULDIV_EN
        return (reset === 1'b1) && ((m_left > 0) || (!m_done && is_md(bus.alu_op_in)));
`else
        return 1'b0;
`endif
    endfunction

    function logic [31:0] model_alu();
        logic [31:0] a, b, rt, imm;
        logic [4:0]  sh;
        logic signed [31:0] rt_s;
        a = bus.read_data_1_in; rt = bus.read_data_2_in; imm = bus.sign_extended_imm_in;
        b = bus.alu_src_in ? imm : rt;
        sh = imm[10:6];
        rt_s = rt;
        case (bus.alu_op_in)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return rt << sh;
            4'd9:  return rt >> sh;
            4'd10: return 32'(rt_s >>> sh);
            4'd11: return {imm[15:0], 16'h0};
            4'd14: return m_hi;
            4'd15: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    task model_edge();
        logic [63:0] prod;
        if (reset !== 1'b1) begin
            e_alu = '0; e_wdata = '0; e_bt = '0; e_wreg = '0;
            e_zero = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_m2r = 0; e_alu_care = 1'b1;
            m_left = 0; m_done = 0; m_hi = '0; m_lo = '0; m_valid = 1'b1;
        end else if (model_stall()) begin
            e_rw = 0; e_mr = 0; e_mw = 0; e_m2r = 0;
            if (m_left == 0) begin
                m_a = bus.read_data_1_in; m_b = bus.read_data_2_in;
                m_div = (bus.alu_op_in == 4'd13);
                m_left = MULDIV_CYCLES;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    if (!m_div) begin
                        prod = {32'd0, m_a} * {32'd0, m_b};
                        m_hi = prod[63:32]; m_lo = prod[31:0];
                    end else if (m_b == 0) begin
                        m_hi = m_a; m_lo = 32'hFFFFFFFF;
                    end else begin
                        m_hi = m_a % m_b; m_lo = m_a / m_b;
                    end
                end
            end
        end else begin
            e_alu = model_alu();
            e_zero = (e_alu == 0);
            e_alu_care = !is_md(bus.alu_op_in);
            e_wdata = bus.read_data_2_in;
            e_bt = bus.next_pc_in + (bus.sign_extended_imm_in << 2);
            e_wreg = bus.reg_dst_in ? bus.rd_in : bus.rt_in;
            e_rw = bus.reg_write_in && !is_md(bus.alu_op_in);
            e_mr = bus.mem_read_in; e_mw = bus.mem_write_in; e_m2r = bus.mem_to_reg_in;
            m_done = 1'b0;
        end
    endtask

    task compare();
        if (!m_valid) return;
        if (e_alu_care) begin
            chk("alu_result", bus.alu_result_out, e_alu);
            chk("zero", 32'(bus.zero_out), 32'(e_zero));
        end
        chk("write_data", bus.write_data_out, e_wdata);
        chk("branch_target", bus.branch_target_out, e_bt);
        chk("write_reg", 32'(bus.write_reg_out), 32'(e_wreg));
        chk("reg_write", 32'(bus.reg_write_out), 32'(e_rw));
        chk("mem_read", 32'(bus.mem_read_out), 32'(e_mr));
        chk("mem_write", 32'(bus.mem_write_out), 32'(e_mw));
        chk("mem_to_reg", 32'(bus.mem_to_reg_out), 32'(e_m2r));
        chk("stall", 32'(bus.stall_out), 32'(model_stall()));
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic rand_inputs();
        bus.read_data_1_in = rnd_word();
        bus.read_data_2_in = rnd_word();
        bus.sign_extended_imm_in = rnd_word();
        bus.rt_in = 5'($urandom_range(0, 31));
        bus.rd_in = 5'($urandom_range(0, 31));
        bus.next_pc_in = $urandom();
        bus.alu_op_in = 4'($urandom_range(0, 15));
        bus.alu_src_in = 1'($urandom_range(0, 1));
        bus.reg_dst_in = 1'($urandom_range(0, 1));
        bus.reg_write_in = 1'($urandom_range(0, 1));
        bus.mem_read_in = 1'($urandom_range(0, 1));
        bus.mem_write_in = 1'($urandom_range(0, 1));
        bus.mem_to_reg_in = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_instr();
        bus.read_data_1_in = '0; bus.read_data_2_in = '0; bus.sign_extended_imm_in = '0;
        bus.rt_in = '0; bus.rd_in = '0; bus.next_pc_in = '0; bus.alu_op_in = '0;
        bus.alu_src_in = 0; bus.reg_dst_in = 0; bus.reg_write_in = 0;
        bus.mem_read_in = 0; bus.mem_write_in = 0; bus.mem_to_reg_in = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the current instruction while stalled; returns the number of stalled cycles.
    task automatic count_stall(output int n);
        n = 0;
        while (bus.stall_out === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic run_md(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input string name, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        clear_instr();
        bus.alu_op_in = op; bus.read_data_1_in = rs; bus.read_data_2_in = rt;
        bus.reg_write_in = 1'b1;
        count_stall(n);
        chk({name, "_stall_cycles"}, 32'(n), 32'(EXP_STALL));
        tick();
        chk({name, "_retire_reg_write"}, 32'(bus.reg_write_out), 32'd0);
        clear_instr(); bus.alu_op_in = 4'd15; tick();
        chk({name, "_mflo"}, bus.alu_result_out, exp_lo);
        clear_instr(); bus.alu_op_in = 4'd14; tick();
        chk({name, "_mfhi"}, bus.alu_result_out, exp_hi);
    endtask

    initial begin
        bit hold;
        reset = 1'b0;
        rand_inputs();
        fork
            forever begin @(posedge clk); model_edge(); end
            forever begin @(negedge clk); compare(); end
            begin
                repeat (100000) @(posedge clk);
                $display("FAIL timeout actual=running required=finished");
                $fatal(1, "timeout");
            end
        join_none

        repeat (3) begin tick(); rand_inputs(); end
        chk("rst_alu_result", bus.alu_result_out, 32'd0);
        chk("rst_branch_target", bus.branch_target_out, 32'd0);
        chk("rst_write_data", bus.write_data_out, 32'd0);
        chk("rst_ctrl", {bus.reg_write_out, bus.mem_read_out, bus.mem_write_out,
                         bus.mem_to_reg_out, bus.zero_out, bus.write_reg_out}, 32'd0);
        chk("rst_stall", 32'(bus.stall_out), 32'd0);

        reset = 1'b1;
        clear_instr();
        bus.read_data_1_in = 32'hA; bus.read_data_2_in = 32'h14;
        bus.rt_in = 5'd2; bus.rd_in = 5'd3; bus.reg_dst_in = 1; bus.reg_write_in = 1;
        tick();
        chk("add_result", bus.alu_result_out, 32'h1E);
        chk("add_write_reg", 32'(bus.write_reg_out), 32'd3);
        chk("add_reg_write", 32'(bus.reg_write_out), 32'd1);
        chk("add_zero", 32'(bus.zero_out), 32'd0);

        clear_instr();
        bus.read_data_1_in = 32'h28; bus.sign_extended_imm_in = 32'hFFFFFFCE;
        bus.alu_src_in = 1; bus.next_pc_in = 32'hC;
        tick();
        chk("addi_result", bus.alu_result_out, 32'hFFFFFFF6);
        chk("branch_target", bus.branch_target_out, 32'hFFFFFF44);

        run_md(4'd12, 32'hFFFFFFFF, 32'h2, "multu", EXP_MUL_LO, EXP_MUL_HI);
        run_md(4'd13, 32'h7, 32'h0, "divu0", EXP_DIV_LO, EXP_DIV_HI);

        clear_instr();
        bus.alu_op_in = 4'd12; bus.read_data_1_in = 32'h3; bus.read_data_2_in = 32'h5;
        repeat (10) tick();
        reset = 1'b0;
        tick();
        chk("midrst_stall_in_reset", 32'(bus.stall_out), 32'd0);
        clear_instr(); bus.alu_op_in = 4'd14;
        reset = 1'b1;
        #1;
        chk("midrst_stall_after", 32'(bus.stall_out), 32'd0);
        tick();
        chk("midrst_mfhi", bus.alu_result_out, 32'd0);

        for (int i = 0; i < 600; i++) begin
            hold = (bus.stall_out === 1'b1);
            reset = ($urandom_range(0, 99) != 0);
            if (!hold) rand_inputs();
            tick();
        end
        reset = 1'b1;
        clear_instr();
        repeat (3) tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
